dsp48a1_mac_sequencer: RTL
==========================

Name: dsp48a1_mac_sequencer

Overview:
- Sequences one DSP48A1 slice as an unsigned multiply-accumulate engine that computes sum(A_i*B_i) over LEN sample pairs.
- Accepts sample pairs on a valid/ready stream and drives the slice's A/B, OPMODE, clock enables and resets.
- Tracks the slice pipeline latency and returns the 48-bit sum on a valid/ready result port.
- Sits between a sample source (FIR/dot-product front end) and one slice instantiated with defaults: A0REG=B0REG=0, A1REG=B1REG=MREG=PREG=OPMODEREG=1, B_INPUT="DIRECT".

Parameters:
LEN_W, 10, width of LEN and sample counter; max job length 2^LEN_W-1
PIPE_LAT, 3, edges from sample-accept edge to P containing that product (A1/B1 + M + P)
OPMODE_MAC, 8'h09, OPMODE driven to slice: X=M, Z=P, pre-adder bypass, post-add, CYI=0

Ports:
CLK  in  1  clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  job start pulse; sampled only in IDLE
LEN  in  LEN_W  number of sample pairs; latched on accepted START
BUSY  out  1  high in any state other than IDLE
IN_VALID  in  1  sample pair valid
IN_READY  out  1  controller accepts a sample pair
IN_A  in  18  multiplicand, unsigned
IN_B  in  18  multiplier, unsigned
RES_VALID  out  1  result valid
RES_READY  in  1  result consumer ready
RES_DATA  out  48  accumulated sum
DSP_A  out  18  to slice A
DSP_B  out  18  to slice B
DSP_OPMODE  out  8  to slice OPMODE
DSP_CE  out  1  to slice CEA, CEB, CEM, CEP, CEOPMODE
DSP_RST  out  1  active-high; to slice RSTA, RSTB, RSTM, RSTP
DSP_P  in  48  from slice P

Behaviour:
- Reset (RST_N low, async): state=IDLE, IN_READY=0, RES_VALID=0, RES_DATA=0, BUSY=0, DSP_CE=0, DSP_RST=0, counters=0.
- States: IDLE, CLEAR, ACCUM, DRAIN, DONE.
- IDLE: DSP_CE=0. On START with LEN!=0: latch LEN into remaining-count and go to CLEAR. On START with LEN=0: RES_DATA<=0, RES_VALID<=1, go to DONE (result is valid 1 cycle after START).
- CLEAR (exactly 1 cycle): DSP_RST=1, DSP_CE=1, DSP_A=DSP_B=0. This zeroes the slice A1/B1/M/P registers and loads OPMODE_MAC into the OPMODE register. Then go to ACCUM.
- ACCUM: IN_READY=1, DSP_CE=1.
  - Accept = IN_VALID&IN_READY. DSP_A/DSP_B = IN_A/IN_B when accept, else 0. A bubble contributes a zero product, so the sum is unaffected.
  - Remaining-count decrements on each accept.
  - On the accept edge where remaining-count==1: load drain counter with PIPE_LAT-1 and go to DRAIN.
- DRAIN: IN_READY=0, DSP_CE=1, DSP_A=DSP_B=0. Drain counter decrements each edge. While counter==0, DSP_P holds the full sum; on that edge RES_DATA<=DSP_P, RES_VALID<=1, go to DONE.
- Latency: the last sample accepted at edge E0 produces RES_VALID high after edge E0+PIPE_LAT (E0+3 at default).
- DONE: DSP_CE=0 (slice holds), RES_VALID=1, RES_DATA stable. On RES_VALID&RES_READY: RES_VALID<=0, go to IDLE.
- Slice-facing outputs outside CLEAR/ACCUM/DRAIN: DSP_A=DSP_B=0, DSP_RST=0.
- DSP_OPMODE=OPMODE_MAC in all states.
- Arithmetic: unsigned 18x18 products, 48-bit accumulation modulo 2^48 (slice wraps, no overflow flag).
- START outside IDLE is ignored. START in the same cycle as result acceptance is ignored; a new job needs START in IDLE.
- IN_VALID outside ACCUM is ignored; no sample is consumed.
- RST_N asserted mid-job: the job is aborted immediately to reset values, with no result. The slice's own contents are cleared by the next job's CLEAR.

Test Plan:
- Reset: RST_N low mid-cycle -> all outputs at reset values immediately; BUSY=0, RES_VALID=0, DSP_CE=0.
- LEN=3, back-to-back pairs (2,3),(4,5),(1,1) -> RES_DATA=27; RES_VALID rises exactly 3 edges after the third accept; CLEAR shows DSP_RST=1 for 1 cycle.
- LEN=3 with IN_VALID gaps (pairs separated by 2 idle cycles) and nonzero garbage on IN_A/IN_B during gaps -> RES_DATA=27, DSP_A/DSP_B=0 during gaps.
- LEN=0 -> RES_VALID 1 cycle after START, RES_DATA=0, DSP_RST never asserted.
- LEN=4, all pairs (0x3FFFF,0x3FFFF) with RES_READY held low 10 cycles -> RES_DATA=48'h003F_FFE0_0004 stable while held; START pulses during the job are ignored; IDLE after handshake.
- Two jobs: first LEN=2 (10,10) -> 200; second LEN=1 (7,6) -> 42, with no carry-over from the first job.
- Reset mid-ACCUM after 1 of 3 samples, then new job LEN=1 (3,3) -> 9.

Source files
------------

// File: rtl/dsp48a1_mac_sequencer_if.sv
// Sample-pair input stream and result output stream of the DSP48A1 MAC sequencer.
// The master is the sample source / result consumer; the slave is the sequencer.
interface dsp48a1_mac_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [17:0] in_a;
    logic [17:0] in_b;
    logic        res_valid;
    logic        res_ready;
    logic [47:0] res_data;

    modport master (
        output in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data
    );

    modport slave (
        input  in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data
    );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// Drives one DSP48A1 slice as an unsigned multiply-accumulate engine over LEN sample
// pairs and returns the 48-bit sum once the slice pipeline has drained.
module dsp48a1_mac_sequencer #(
    parameter int          LEN_W      = 10,
    parameter int          PIPE_LAT   = 3,
    parameter logic [7:0]  OPMODE_MAC = 8'h09
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [LEN_W-1:0]     len,
    output logic                 busy,
    dsp48a1_mac_sequencer_if.slave s,
    output logic [17:0]          dsp_a,
    output logic [17:0]          dsp_b,
    output logic [7:0]           dsp_opmode,
    output logic                 dsp_ce,
    output logic                 dsp_rst,
    input  logic [47:0]          dsp_p
);

    localparam int DRAIN_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        DRAIN,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   rem_q, rem_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic [47:0]        res_data_q, res_data_d;
    logic               res_valid_q, res_valid_d;
    logic               accept;

    assign accept      = (state_q == ACCUM) && s.in_valid;
    assign s.in_ready  = (state_q == ACCUM);
    assign s.res_valid = res_valid_q;
    assign s.res_data  = res_data_q;
    assign busy        = (state_q != IDLE);
    assign dsp_ce      = (state_q == CLEAR) || (state_q == ACCUM) || (state_q == DRAIN);
    assign dsp_rst     = (state_q == CLEAR);
    assign dsp_opmode  = OPMODE_MAC;
    // Bubbles feed zeros so an idle input cycle adds a zero product to the sum.
    assign dsp_a       = accept ? s.in_a : '0;
    assign dsp_b       = accept ? s.in_b : '0;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through this block infers a latch.
        state_d     = state_q;
        rem_d       = rem_q;
        drain_d     = drain_q;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        rem_d   = len;
                        state_d = CLEAR;
                    end else begin
                        res_data_d  = '0;
                        res_valid_d = 1'b1;
                        state_d     = DONE;
                    end
                end
            end
            CLEAR: state_d = ACCUM;
            ACCUM: begin
                if (accept) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        drain_d = DRAIN_W'(PIPE_LAT - 1);
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // P holds the complete sum once the last product has passed A1/B1, M and P.
                if (drain_q == '0) begin
                    res_data_d  = dsp_p;
                    res_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end
            DONE: begin
                if (s.res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rem_q       <= '0;
            drain_q     <= '0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            drain_q     <= drain_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

endmodule
